// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RISC-V M-extension
// function codes, FSM state encodings and operand signedness lookup.
package mdu_pkg;

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // operand_idx 0 selects rs1, 1 selects rs2. MUL is treated as signed; its
  // low product half is identical either way.
  function automatic logic is_signed_op(input logic [2:0] fn, input logic operand_idx);
    case (fn)
      FN_MUL, FN_MULH, FN_DIV, FN_REM: return 1'b1;
      FN_MULHSU:                       return ~operand_idx;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used to take operand magnitudes and
// to restore the sign of finished results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mul_div_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one radix-2 step per cycle on
// operand magnitudes, with a one-cycle fast path for divide special cases.
module mul_div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [2:0]       io_req_fn,
  input  logic [XLEN-1:0]  io_req_in1,
  input  logic [XLEN-1:0]  io_req_in2,
  input  logic [TAG_W-1:0] io_req_tag,
  input  logic             io_kill,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic [XLEN-1:0]  io_resp_data,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic [1:0]       io_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. io_kill overrides both request acceptance and response transfer.

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("mul_div_iter: XLEN must be 32 or 64");
  end

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        fn_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   resp_data_q;

  // Operand capture
  logic            s1, s2;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            accept, div_zero, div_ovf;
  logic [XLEN-1:0] special_data;

  assign s1 = is_signed_op(io_req_fn, 1'b0) & io_req_in1[XLEN-1];
  assign s2 = is_signed_op(io_req_fn, 1'b1) & io_req_in2[XLEN-1];

  mdu_sign_fix #(.W(XLEN)) u_fix_a (.val(io_req_in1), .neg(s1), .res(a_mag_in));
  mdu_sign_fix #(.W(XLEN)) u_fix_b (.val(io_req_in2), .neg(s2), .res(b_mag_in));

  assign accept   = io_req_valid & io_req_ready & ~io_kill;
  assign div_zero = io_req_fn[2] & (io_req_in2 == '0);
  assign div_ovf  = io_req_fn[2] & ~io_req_fn[0] & (io_req_in1 == MOST_NEG) & (io_req_in2 == '1);

  // fn[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    special_data = '0;
    if (div_zero)     special_data = io_req_fn[1] ? io_req_in1 : '1;
    else if (div_ovf) special_data = io_req_fn[1] ? '0 : io_req_in1;
  end

  // One iteration step
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   rem_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_mag};
    acc_nxt   = acc;
    rem_nxt   = rem;
    if (fn_q[2]) begin
      rem_nxt = div_ge ? XLEN'(div_shift - {1'b0, b_mag}) : div_shift[XLEN-1:0];
      acc_nxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Result finalisation from the last step's values
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_raw, div_fixed, final_data;

  assign div_raw = fn_q[1] ? rem_nxt : acc_nxt[XLEN-1:0];

  mdu_sign_fix #(.W(2*XLEN)) u_fix_prod (.val(acc_nxt), .neg(neg_q), .res(prod_fixed));
  mdu_sign_fix #(.W(XLEN)) u_fix_div (
    .val(div_raw), .neg(fn_q[1] ? neg_r : neg_q), .res(div_fixed)
  );

  always_comb begin
    final_data = prod_fixed[2*XLEN-1:XLEN];
    if (fn_q[2])              final_data = div_fixed;
    else if (fn_q == FN_MUL)  final_data = prod_fixed[XLEN-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      fn_q        <= '0;
      tag_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_mag       <= '0;
      acc         <= '0;
      rem         <= '0;
      resp_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fn_q  <= io_req_fn;
            tag_q <= io_req_tag;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            b_mag <= b_mag_in;
            acc   <= {{XLEN{1'b0}}, a_mag_in};
            rem   <= '0;
            cnt   <= CNT_W'(XLEN-1);
            if (div_zero || div_ovf) begin
              resp_data_q <= special_data;
              state       <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (io_kill) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              resp_data_q <= final_data;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (io_kill || io_resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_req_ready  = (state == ST_IDLE);
  assign io_resp_valid = (state == ST_DONE);
  assign io_resp_data  = resp_data_q;
  assign io_resp_tag   = tag_q;
  assign io_dbg_state  = state;

endmodule

// File: doc/mul_div_iter.md
Name: mul_div_iter

Overview:
- Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operations.
- Sits beside the combinational ALU in the execute stage. Decode steers M-extension ops here.
- Uses a valid/ready request/response handshake, so the pipeline stalls while the unit is busy.
- Carries a register tag through to the response for writeback.

Parameters:
- XLEN, 32, operand and result width in bits; must be 32 or 64.
- TAG_W, 5, width of the destination-register tag passed through unchanged.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- io_req_valid  in  1  request present.
- io_req_ready  out  1  unit can accept a request.
- io_req_fn  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- io_req_in1  in  XLEN  rs1 operand.
- io_req_in2  in  XLEN  rs2 operand.
- io_req_tag  in  TAG_W  destination tag.
- io_kill  in  1  flush; aborts any in-flight operation.
- io_resp_valid  out  1  result available.
- io_resp_ready  in  1  consumer takes result.
- io_resp_data  out  XLEN  result.
- io_resp_tag  out  TAG_W  tag captured with the request.

Behaviour:
- Reset (async, reset_n=0): state IDLE; io_req_ready=1; io_resp_valid=0; io_resp_data=0; io_resp_tag=0; internal counter and accumulators cleared.
- Reset asserted mid-operation discards the operation with no response.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: io_req_ready=1. A request is accepted when io_req_valid and io_req_ready are both high on a clock edge; the unit latches fn, tag, operand magnitudes and sign flags.
  - IDLE -> DONE on a special case, IDLE -> BUSY otherwise.
  - BUSY: io_req_ready=0. One radix-2 iteration per cycle; counter runs XLEN-1 down to 0. BUSY -> DONE after the iteration at counter 0.
  - DONE: io_resp_valid=1 and io_req_ready=0. Data and tag are held stable until io_resp_ready=1 on an edge, then DONE -> IDLE. No back-to-back acceptance in the same cycle.
- Latency, request edge to first io_resp_valid:
  - XLEN+1 cycles for a normal op.
  - 1 cycle for a special case.
- Sign handling:
  - Signed operands are converted to magnitudes before iteration.
  - MULH treats both operands as signed. MULHSU treats in1 as signed and in2 as unsigned. MULHU, DIVU and REMU treat both as unsigned.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Multiply: shift-add into a 2*XLEN accumulator. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- Special cases (fast path, no iteration):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return in1.
  - Signed overflow (DIV/REM with in1 = most-negative and in2 = -1): DIV returns in1; REM returns 0.
- io_kill:
  - In BUSY or DONE: next state IDLE, io_resp_valid=0, no response.
  - In IDLE: the unit does not accept a request presented that cycle.
  - Kill has priority over request acceptance and over response handshake.
- Tags are never altered; io_resp_tag equals the accepted io_req_tag.

Decomposition:
- Shared package (mdu_pkg):
  - Function-code localparams FN_MUL..FN_REMU.
  - State encodings ST_IDLE, ST_BUSY, ST_DONE.
  - Helper function is_signed_op(fn, operand_idx).
- One sub-module, mdu_sign_fix: combinational magnitude/negation helper, used at operand capture and at result finalisation.
- The datapath iteration and the FSM stay in mul_div_iter.

Test Plan:
- XLEN=32, MUL 5*7 tag=3 -> io_resp_valid 33 cycles after acceptance; data=35, tag=3; io_req_ready=0 throughout.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV -20/3 -> 0xFFFFFFFA (-6).
  - REM -20/3 -> 0xFFFFFFFE (-2).
  - DIVU 20/3 -> 6.
  - REMU 20/3 -> 2.
- Special cases, each with io_resp_valid one cycle after acceptance:
  - DIVU 9/0 -> 0xFFFFFFFF.
  - REM 9/0 -> 9.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Handshake and abort:
  - Hold io_resp_ready=0 for 5 cycles in DONE -> data and tag stable; io_req_ready=0.
  - Assert io_kill at BUSY cycle 10 -> no io_resp_valid; io_req_ready=1 on the next cycle.
- Drop reset_n asynchronously mid-BUSY -> outputs go to reset values immediately. After release, a new MUL 20*2 returns 40.
